// File: rtl/tdc_therm_decoder.sv
// Carry-chain TDC back end: bubble-filters the registered tap vector, detects the hit edge and
// emits a coarse/fine timestamp through a single-entry valid/ready output register.
module tdc_therm_decoder #(
    parameter int unsigned N        = 16,
    parameter int unsigned COARSE_W = 8,
    parameter int unsigned FINE_W   = $clog2(N + 1)
) (
    input  logic                clk,
    input  logic                sclr,
    input  logic [N-1:0]        chain_q,
    input  logic                ts_ready,
    output logic                ts_valid,
    output logic [COARSE_W-1:0] ts_coarse,
    output logic [FINE_W-1:0]   ts_fine,
    output logic                ts_sat,
    output logic [15:0]         drop_cnt,
    output logic                armed
);
    typedef enum logic [1:0] {StWaitIdle, StArmed, StBusy} state_e;

    logic [COARSE_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]        s1_chain_q, s1_chain_d;
    logic [COARSE_W-1:0] s1_coarse_q, s1_coarse_d;
    logic                s1_vld_q, s1_vld_d;
    logic [N-1:0]        f_q, f_d;
    logic [COARSE_W-1:0] s2_coarse_q, s2_coarse_d;
    logic                s2_vld_q, s2_vld_d;
    state_e              state_q, state_d;
    logic                armed_q, armed_d;
    logic                ts_valid_q, ts_valid_d;
    logic [COARSE_W-1:0] ts_coarse_q, ts_coarse_d;
    logic [FINE_W-1:0]   ts_fine_q, ts_fine_d;
    logic                ts_sat_q, ts_sat_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic [FINE_W-1:0]   zeros;
    logic                hit, load;

    // Pipeline front end: S1 capture and S2 majority filter. The valid flags keep the FSM
    // from arming on flushed data until real samples have reached S2.
    always_comb begin
        cnt_d       = cnt_q + COARSE_W'(1);
        s1_chain_d  = chain_q;
        s1_coarse_d = cnt_q;
        s1_vld_d    = 1'b1;
        f_d         = s1_chain_q;
        for (int i = 1; i < int'(N) - 1; i++) begin
            f_d[i] = (s1_chain_q[i-1] & s1_chain_q[i]) | (s1_chain_q[i] & s1_chain_q[i+1]) |
                     (s1_chain_q[i-1] & s1_chain_q[i+1]);
        end
        s2_coarse_d = s1_coarse_q;
        s2_vld_d    = s1_vld_q;
    end

    always_comb begin
        zeros = '0;
        for (int i = 0; i < int'(N); i++) begin
            zeros = zeros + FINE_W'(!f_q[i]);
        end
    end

    always_comb begin
        hit     = 1'b0;
        state_d = state_q;
        unique case (state_q)
            StWaitIdle: if (s2_vld_q && (&f_q)) state_d = StArmed;
            StArmed: begin
                if (s2_vld_q && !f_q[0]) begin
                    hit     = 1'b1;
                    state_d = StBusy;
                end
            end
            StBusy:     if (s2_vld_q && (&f_q)) state_d = StArmed;
            default:    state_d = StWaitIdle;
        endcase
        armed_d = (state_d == StArmed);

        // A capture may reuse the slot in the same cycle its previous contents transfer out.
        load        = hit && (!ts_valid_q || ts_ready);
        ts_valid_d  = load ? 1'b1 : (ts_ready ? 1'b0 : ts_valid_q);
        ts_coarse_d = load ? s2_coarse_q : ts_coarse_q;
        ts_fine_d   = load ? zeros : ts_fine_q;
        ts_sat_d    = load ? (zeros == FINE_W'(N)) : ts_sat_q;
        drop_cnt_d  = drop_cnt_q;
        if (hit && !load && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            cnt_q       <= '0;
            s1_chain_q  <= '1;
            s1_coarse_q <= '0;
            s1_vld_q    <= 1'b0;
            f_q         <= '1;
            s2_coarse_q <= '0;
            s2_vld_q    <= 1'b0;
            state_q     <= StWaitIdle;
            armed_q     <= 1'b0;
            ts_valid_q  <= 1'b0;
            ts_coarse_q <= '0;
            ts_fine_q   <= '0;
            ts_sat_q    <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            s1_chain_q  <= s1_chain_d;
            s1_coarse_q <= s1_coarse_d;
            s1_vld_q    <= s1_vld_d;
            f_q         <= f_d;
            s2_coarse_q <= s2_coarse_d;
            s2_vld_q    <= s2_vld_d;
            state_q     <= state_d;
            armed_q     <= armed_d;
            ts_valid_q  <= ts_valid_d;
            ts_coarse_q <= ts_coarse_d;
            ts_fine_q   <= ts_fine_d;
            ts_sat_q    <= ts_sat_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign ts_valid  = ts_valid_q;
    assign ts_coarse = ts_coarse_q;
    assign ts_fine   = ts_fine_q;
    assign ts_sat    = ts_sat_q;
    assign drop_cnt  = drop_cnt_q;
    assign armed     = armed_q;

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// Scoreboard bench for tdc_therm_decoder: stimulus pushes expected timestamps, a negedge
// monitor pops and compares them on every ts_valid & ts_ready transfer.
module tb_tdc_therm_decoder;
    localparam int unsigned N = 16;
    localparam int unsigned COARSE_W = 8;
    localparam int unsigned FINE_W = 5;

    typedef struct packed {
        logic [COARSE_W-1:0] coarse;
        logic [FINE_W-1:0]   fine;
        logic                sat;
    } exp_t;

    logic                clk = 1'b0;
    logic                sclr = 1'b1;
    logic [N-1:0]        chain_q = 16'hFFFF;
    logic                ts_ready = 1'b1;
    logic                ts_valid;
    logic [COARSE_W-1:0] ts_coarse;
    logic [FINE_W-1:0]   ts_fine;
    logic                ts_sat;
    logic [15:0]         drop_cnt;
    logic                armed;

    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    logic [COARSE_W-1:0] tb_cnt = '0;
    logic [COARSE_W-1:0] c_hold;
    logic v2, v3;

    tdc_therm_decoder #(.N(N), .COARSE_W(COARSE_W), .FINE_W(FINE_W)) dut (
        .clk(clk), .sclr(sclr), .chain_q(chain_q), .ts_ready(ts_ready), .ts_valid(ts_valid),
        .ts_coarse(ts_coarse), .ts_fine(ts_fine), .ts_sat(ts_sat), .drop_cnt(drop_cnt),
        .armed(armed)
    );

    always #5 clk = ~clk;

    // Reference coarse counter: the value visible during the current cycle.
    always @(posedge clk) tb_cnt <= sclr ? '0 : tb_cnt + 8'd1;

    always @(negedge clk) begin
        if (ts_valid === 1'b1 && ts_ready === 1'b1) begin
            exp_t got, want;
            got = '{coarse: ts_coarse, fine: ts_fine, sat: ts_sat};
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ts: got coarse=%0h fine=%0d sat=%0b, none expected",
                         ts_coarse, ts_fine, ts_sat);
            end else begin
                want = sb_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL ts_fields: got coarse=%0h fine=%0d sat=%0b, want coarse=%0h fine=%0d sat=%0b",
                             ts_coarse, ts_fine, ts_sat, want.coarse, want.fine, want.sat);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic wait_cnt(input logic [COARSE_W-1:0] v);
        for (int i = 0; i < 300 && tb_cnt != v; i++) step();
        check("wait_cnt", 32'(tb_cnt), 32'(v));
    endtask

    // Hit sample, 4 cycles of full span, then all-ones long enough to rearm.
    task automatic hit(input logic [N-1:0] pat, input logic push, input logic [FINE_W-1:0] fine,
                       input logic sat, output logic valid_t2, output logic valid_t3);
        if (push) sb_q.push_back('{coarse: tb_cnt, fine: fine, sat: sat});
        chain_q = pat;
        step();
        chain_q = 16'h0000;
        step();
        valid_t2 = ts_valid;
        step();
        valid_t3 = ts_valid;
        step();
        step();
        chain_q = 16'hFFFF;
        for (int i = 0; i < 6; i++) step();
    endtask

    initial begin
        // 1. Reset and arm
        sclr = 1'b1;
        step();
        check("rst_valid", 32'(ts_valid), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        check("rst_armed", 32'(armed), 0);
        check("rst_fields", {ts_coarse, ts_fine, ts_sat}, 0);
        step();
        sclr = 1'b0;
        step();
        step();
        check("armed_early", 32'(armed), 0);
        step();
        check("armed_t3", 32'(armed), 1);
        check("idle_valid", 32'(ts_valid), 0);

        // 2. Basic hit with latency check
        wait_cnt(8'h25);
        hit(16'hFFF8, 1'b1, 5'd3, 1'b0, v2, v3);
        check("lat_t2_idle", 32'(v2), 0);
        check("lat_t3_valid", 32'(v3), 1);
        check("rearm", 32'(armed), 1);

        // 3. Bubble correction
        hit(16'hFFF2, 1'b1, 5'd4, 1'b0, v2, v3);

        // 4. Saturation and coarse wrap
        hit(16'h0000, 1'b1, 5'd16, 1'b1, v2, v3);
        wait_cnt(8'hFF);
        sb_q.push_back('{coarse: 8'hFF, fine: 5'd1, sat: 1'b0});
        chain_q = 16'hFFFE;
        step();
        chain_q = 16'hFFFF;
        step();
        step();
        sb_q.push_back('{coarse: tb_cnt, fine: 5'd1, sat: 1'b0});
        check("wrap_cnt", 32'(tb_cnt), 32'h02);
        chain_q = 16'hFFFE;
        step();
        chain_q = 16'hFFFF;
        for (int i = 0; i < 6; i++) step();

        // 5. Backpressure: first held, next two dropped
        ts_ready = 1'b0;
        c_hold = tb_cnt;
        hit(16'hFFF0, 1'b1, 5'd4, 1'b0, v2, v3);
        hit(16'hFF00, 1'b0, 5'd0, 1'b0, v2, v3);
        hit(16'hF000, 1'b0, 5'd0, 1'b0, v2, v3);
        check("bp_drop", 32'(drop_cnt), 2);
        check("bp_valid_held", 32'(ts_valid), 1);
        check("bp_stable", {ts_coarse, ts_fine, ts_sat}, {c_hold, 5'd4, 1'b0});
        ts_ready = 1'b1;
        step();
        check("bp_drain", 32'(ts_valid), 0);
        ts_ready = 1'b0;
        hit(16'hFFF8, 1'b1, 5'd3, 1'b0, v2, v3);
        sb_q.push_back('{coarse: tb_cnt, fine: 5'd6, sat: 1'b0});
        chain_q = 16'hFFC0;
        step();
        chain_q = 16'h0000;
        step();
        ts_ready = 1'b1;
        step();
        check("b2b_valid", 32'(ts_valid), 1);
        check("b2b_fine", 32'(ts_fine), 6);
        step();
        chain_q = 16'hFFFF;
        for (int i = 0; i < 6; i++) step();
        check("b2b_no_drop", 32'(drop_cnt), 2);

        // 6. Reset mid-hit with a pending timestamp
        ts_ready = 1'b0;
        hit(16'hFFF8, 1'b0, 5'd0, 1'b0, v2, v3);
        check("pend_valid", 32'(ts_valid), 1);
        chain_q = 16'hFF00;
        sclr = 1'b1;
        step();
        step();
        check("sclr_discard", 32'(ts_valid), 0);
        check("sclr_drop", 32'(drop_cnt), 0);
        sclr = 1'b0;
        ts_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("held_hit_valid", 32'(ts_valid), 0);
        check("held_hit_armed", 32'(armed), 0);
        chain_q = 16'hFFFF;
        step();
        step();
        step();
        check("rst_rearm", 32'(armed), 1);
        hit(16'hFF80, 1'b1, 5'd7, 1'b0, v2, v3);
        check("post_rst_valid_t3", 32'(v3), 1);

        for (int i = 0; i < 4; i++) step();
        check("sb_empty", 32'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tdc_therm_decoder.md
Name: tdc_therm_decoder

Overview:
- Consumer end of the carry-chain TDC delay line. Takes the N-bit registered chain tap vector each clock.
- Applies bubble correction, detects a hit edge and converts the thermometer code to a fine count.
- Pairs the fine count with a free-running coarse count and presents the timestamp on a valid/ready output.
- Sits directly after the carry-chain FF bank, upstream of timestamp FIFO/readout logic.

Parameters:
- N, 16: delay-line length, equal to the number of chain_q bits.
- COARSE_W, 8: width of the free-running coarse counter.
- FINE_W, $clog2(N+1): fine-count width; holds values 0..N.

Ports:
- clk  in  1  system clock; same clock as the chain FFs.
- sclr  in  1  synchronous active-high reset.
- chain_q  in  N  registered chain taps. Idle is all ones. A hit drives zeros upward from bit 0.
- ts_ready  in  1  downstream accepts the timestamp.
- ts_valid  out  1  timestamp available.
- ts_coarse  out  COARSE_W  coarse count at the hit sample.
- ts_fine  out  FINE_W  number of zero taps after filtering.
- ts_sat  out  1  hit already spanned the whole chain on its first sample.
- drop_cnt  out  16  saturating count of hits lost because the output was full.
- armed  out  1  decoder is waiting for a hit.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on sclr. All outputs and internal registers clear on the clk edge where sclr=1:
  - ts_valid=0, ts_coarse=0, ts_fine=0, ts_sat=0, drop_cnt=0, armed=0.
  - coarse counter=0.
  - FSM enters WAIT_IDLE.
- Coarse counter: increments every cycle and wraps from 2^COARSE_W-1 to 0.
- S1 register stage: chain_q is registered together with the current coarse counter value.
- S2 bubble filter, registered:
  - f[0]=q[0] and f[N-1]=q[N-1].
  - f[i]=majority(q[i-1],q[i],q[i+1]) for 0<i<N-1.
  - Coarse value travels alongside the data.
- S3 decode, registered:
  - zeros = number of 0 bits in f, range 0..N.
  - FSM acts on f, per the states below.
- Latency: chain_q presented in cycle t appears as ts_valid=1 in cycle t+3 (when output slot free).
- ts_coarse equals the counter value present in cycle t.
- FSM states:
  - WAIT_IDLE: armed=0. Go to ARMED when f is all ones.
  - ARMED: armed=1. If f[0]==0, capture a hit and go to BUSY.
  - BUSY: armed=0. Go to ARMED when f is all ones. Zeros seen in BUSY are never captured again.
- Hit capture:
  - fine=zeros.
  - sat=1 if zeros==N, else 0.
  - coarse = the pipelined coarse value of that sample.
- Output handshake:
  - Single-entry output register; transfer happens on ts_valid & ts_ready.
  - ts_* fields hold stable while ts_valid=1 and ts_ready=0.
  - When ts_valid=0, or a transfer occurs in the same cycle, a capture loads the register and ts_valid=1 next cycle. Capture and accept in the same cycle therefore gives back-to-back valid with no bubble.
  - When ts_valid=1 and ts_ready=0, a capture is dropped. drop_cnt increments, saturating at 16'hFFFF. The FSM still moves to BUSY.
- sclr mid-operation:
  - Any pending timestamp is discarded (ts_valid=0).
  - Pipeline contents are flushed to all ones, which is not a hit.
  - FSM starts in WAIT_IDLE, so a chain still carrying a hit is not falsely timestamped. First arm happens no earlier than 3 cycles after sclr deasserts, with all-ones input.
- A single isolated 0 at bit 0 with ones around it still triggers, because f[0]=q[0]. Bubbles at i>0 are corrected by the filter.

Test Plan (N=16, COARSE_W=8):
1. Reset and arm: sclr high 2 cycles, then chain_q=16'hFFFF -> armed=1 three cycles after sclr falls; ts_valid stays 0; drop_cnt=0.
2. Basic hit:
   - Stimulus: armed, ts_ready=1. Apply chain_q=16'hFFF8 in the cycle the coarse counter reads 8'h25, then 16'h0000 for 4 cycles, then 16'hFFFF.
   - Response: exactly one ts_valid pulse, 3 cycles later, with ts_fine=3, ts_coarse=8'h25, ts_sat=0. armed returns to 1 after the all-ones input propagates.
3. Bubble correction: hit sample chain_q=16'hFFF2 -> ts_fine=4 (raw zero count is 3), ts_sat=0.
4. Saturation and wrap:
   - Hit sample 16'h0000 -> ts_fine=16, ts_sat=1.
   - Repeat with the hit sampled at coarse value 8'hFF -> ts_coarse=8'hFF; the next capture after wrap reports the small value, e.g. 8'h02.
5. Backpressure:
   - Hold ts_ready=0 and inject 3 separate hits, each followed by all-ones rearm.
   - Response: the first timestamp is held stable; drop_cnt=2.
   - Raise ts_ready -> one transfer; ts_valid=0 next cycle.
   - Repeat with ts_ready=1 during a capture cycle -> no drop.
6. Reset mid-hit:
   - Assert sclr while chain_q=16'hFF00 is held, release with that pattern still held -> no ts_valid, armed=0.
   - Apply 16'hFFFF -> armed=1.
   - Next hit decodes normally.
